fb_scanout_reader: RTL and testbench

Display-side consumer of the double-buffered SDRAM frame buffer: on each line request it fetches one 640-pixel line (40 × 128-bit words, 8 bpp palette indices) from the frame buffer not currently being drawn. It stores the line in a ping-pong line buffer and serves bytes to the VGA pixel path. It sits downstream of the background/sprite drawing stages that fill the frame buffers and shares their SDRAM handshake (`sdram_wait`/`sdram_ac`).

---
 rtl/fb_pkg.sv | 14 +
 rtl/line_buffer_2x40.sv | 28 ++
 rtl/fb_scanout_reader.sv | 129 ++++++++++++
 tb/tb_fb_scanout_reader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer constants, word-address type and scanout FSM states
// shared by the drawing stages and the scanout reader.
package fb_pkg;
    typedef logic [21:0] addr_t;
    localparam addr_t FB_BASE0       = 22'h100000;
    localparam addr_t FB_BASE1       = 22'h200000;
    localparam int    WORDS_PER_LINE = 40;
    localparam int    LINES          = 480;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_STORE, S_PAUSE, S_DONE} scan_state_t;
    // n * 40 as two shifts and an add
    function automatic addr_t line_offset(input logic [8:0] n);
        return (addr_t'(n) << 5) + (addr_t'(n) << 3);
    endfunction
endpackage

// File: rtl/line_buffer_2x40.sv
// line_buffer_2x40: ping-pong line store, two banks of 40 x 128-bit words.
// Ports: clk, reset_n (async, active-low, clears only the read register);
//   write port wr_en/wr_bank/wr_word/wr_data (one 128-bit word per cycle);
//   read port rd_bank/pix_x -> rd_byte, registered, byte 0 = bits [7:0],
//   pix_x beyond the visible line reads as 0.
module line_buffer_2x40
    import fb_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic         wr_bank,
    input  logic [5:0]   wr_word,
    input  logic [127:0] wr_data,
    input  logic         rd_bank,
    input  logic [9:0]   pix_x,
    output logic [7:0]   rd_byte
);
    logic [127:0] mem [2][WORDS_PER_LINE];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_bank][wr_word] <= wr_data;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rd_byte <= '0;
        else rd_byte <= (pix_x >= 10'(WORDS_PER_LINE * 16)) ? 8'h00
                        : mem[rd_bank][pix_x[9:4]][{pix_x[3:0], 3'b000} +: 8];
endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: fetches one 640-pixel line per line_req from the frame
// buffer not being drawn into a ping-pong line buffer and serves palette
// indices to the pixel path.
// Ports: clk, reset_n (async, active-low); frame_flip, line_req, line_num
//   (request side); sdram_wait/sdram_ac/sdram_rddata -> sdram_rd/sdram_addr
//   (SDRAM read handshake); busy, line_ready, underrun (status);
//   pix_x -> pix_index (registered pixel read from the display bank).
// Option: FB_SCANOUT_UNDERRUN_EN adds the sticky underrun flag and blanks
//   the display of a line whose fill was aborted.
module fb_scanout_reader
    import fb_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         frame_flip,
    input  logic         line_req,
    input  logic [8:0]   line_num,
    input  logic         sdram_wait,
    input  logic         sdram_ac,
    input  logic [127:0] sdram_rddata,
    output logic         sdram_rd,
    output logic [21:0]  sdram_addr,
    output logic         busy,
    output logic         line_ready,
    output logic         underrun,
    input  logic [9:0]   pix_x,
    output logic [7:0]   pix_index
);
    scan_state_t state, state_nx;
    addr_t       addr, base, base_nx;
    logic [5:0]  count;
    logic        fill_sel, req_ok, wr_en;
    logic [7:0]  rd_byte;

    assign req_ok  = line_req && (line_num < 9'(LINES));
    // line 0 starts a new frame: latch the bank the drawers are not using
    assign base_nx = (line_num == '0) ? (frame_flip ? FB_BASE0 : FB_BASE1) : base;
    // a word landing together with a new request belongs to the dropped fill
    assign wr_en   = (state == S_READ) && sdram_ac && !req_ok;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx   = state;
        sdram_rd   = 1'b0;
        busy       = 1'b0;
        line_ready = 1'b0;
        case (state)
            S_IDLE: ;
            S_READ: begin
                sdram_rd = 1'b1;
                busy     = 1'b1;
                if (sdram_ac) state_nx = S_STORE;
            end
            S_STORE: begin
                busy     = 1'b1;
                state_nx = (count == 6'(WORDS_PER_LINE - 1)) ? S_DONE
                         : (sdram_wait ? S_PAUSE : S_READ);
            end
            S_PAUSE: if (!sdram_wait) state_nx = S_READ;
            S_DONE: begin
                line_ready = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // a new request restarts from any state
        if (req_ok) state_nx = sdram_wait ? S_PAUSE : S_READ;
    end

    assign sdram_addr = sdram_rd ? addr : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr     <= '0;
            base     <= FB_BASE1;
            count    <= '0;
            fill_sel <= 1'b0;
        end else if (req_ok) begin
            fill_sel <= ~fill_sel;
            base     <= base_nx;
            addr     <= base_nx + line_offset(line_num);
            count    <= '0;
        end else if (state == S_STORE) begin
            addr  <= addr + 22'd1;
            count <= count + 6'd1;
        end
    end

    line_buffer_2x40 u_lbuf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_bank (fill_sel),
        .wr_word (count),
        .wr_data (sdram_rddata),
        .rd_bank (~fill_sel),
        .pix_x   (pix_x),
        .rd_byte (rd_byte)
    );

`ifdef FB_SCANOUT_UNDERRUN_EN
    logic [1:0] blank;
    logic       blank_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
            blank    <= '0;
            blank_q  <= 1'b0;
        end else begin
            if (req_ok) begin
                underrun        <= (underrun && line_num != '0) || state != S_IDLE;
                // the bank handed to the display is blanked if its fill was cut short
                blank[fill_sel] <= state != S_IDLE && state != S_DONE;
            end
            // tracks the read register so bank and blank switch on the same edge
            blank_q <= blank[~fill_sel];
        end
    end

    assign pix_index = blank_q ? 8'h00 : rd_byte;
`else
    assign underrun  = 1'b0;
    assign pix_index = rd_byte;
`endif
endmodule

// File: tb/tb_fb_scanout_reader.sv
module tb_fb_scanout_reader;
    logic         clk = 1'b0, reset_n = 1'b0, frame_flip = 1'b0, line_req = 1'b0;
    logic [8:0]   line_num = '0;
    logic         sdram_wait = 1'b0, sdram_ac = 1'b0;
    logic [127:0] sdram_rddata = '0;
    logic         sdram_rd, busy, line_ready, underrun;
    logic [21:0]  sdram_addr;
    logic [9:0]   pix_x = '0;
    logic [7:0]   pix_index;

    fb_scanout_reader dut (
        .clk(clk), .reset_n(reset_n), .frame_flip(frame_flip), .line_req(line_req),
        .line_num(line_num), .sdram_wait(sdram_wait), .sdram_ac(sdram_ac),
        .sdram_rddata(sdram_rddata), .sdram_rd(sdram_rd), .sdram_addr(sdram_addr),
        .busy(busy), .line_ready(line_ready), .underrun(underrun),
        .pix_x(pix_x), .pix_index(pix_index)
    );

    always #5 clk = ~clk;

    typedef enum {D_UNKNOWN, D_BLANK, D_VALID} disp_t;
    typedef struct {logic [7:0] v; int c;} px_t;

    int          n_cmp = 0, n_bad = 0, cyc = 0;
    int          ac_pct = 50, pause_cnt = 0, fill_words = 0, req_cyc = 0, ready_cyc = 0;
    bit          fill_active = 0, fill_done = 0, underrun_m = 0, pause_at = 0, rand_wait = 0;
    logic [21:0] exp_addr[$];
    px_t         pq[$];
    px_t         mon_p;
    logic [21:0] base_m = 22'h200000, fill_addr = '0, disp_addr = '0;
    disp_t       disp_m = D_UNKNOWN;

    // SDRAM contents: every byte of a word depends on the word address
    function automatic logic [127:0] word_of(input logic [21:0] a);
        logic [31:0] x;
        x = {10'b0, a};
        return {x * 32'h9E3779B1, (x * 32'h85EBCA6B) ^ 32'h0BADF00D,
                x * 32'hC2B2AE35 + 32'd7, ~x * 32'h27D4EB2F};
    endfunction

    function automatic logic [7:0] pix_of(input int x, input logic [21:0] line_addr);
        logic [127:0] w;
        w = word_of(line_addr + 22'(x / 16));
        return w[8 * (x % 16) +: 8];
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", n, act, want, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SDRAM responder
    initial forever begin
        @(posedge clk);
        #2;
        if (pause_cnt > 0) begin
            pause_cnt--;
            sdram_wait = 1'b1;
        end else sdram_wait = rand_wait && ($urandom_range(0, 7) == 0);
        sdram_ac     = sdram_rd && (int'($urandom_range(0, 99)) < ac_pct);
        sdram_rddata = sdram_ac ? word_of(sdram_addr) : {4{$urandom}};
        if (sdram_ac && !line_req) begin
            fill_words++;
            if (pause_at && fill_words == 4) begin
                pause_at   = 0;
                sdram_wait = 1'b1;
                pause_cnt  = 9;
            end
        end
    end

    // monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (sdram_rd && sdram_ac && !line_req) begin
            if (exp_addr.size() == 0) chk("addr_extra", 32'(exp_addr.size()), 32'd1);
            else chk("rd_addr", 32'(sdram_addr), 32'(exp_addr.pop_front()));
        end
        if (!sdram_rd) chk("addr_idle", 32'(sdram_addr), 32'd0);
        if (line_ready) begin
            chk("ready_words_left", 32'(exp_addr.size()), 32'd0);
            chk("ready_expected", 32'(fill_active), 32'd1);
            fill_active = 0;
            fill_done   = 1;
            ready_cyc   = cyc;
        end
        while (pq.size() > 0 && pq[0].c < cyc) begin
            mon_p = pq.pop_front();
            chk("pix_index", 32'(pix_index), 32'(mon_p.v));
        end
    end

    task automatic issue_req(input int ln, input bit fl);
        @(posedge clk);
        #1;
        frame_flip = fl;
        line_num   = 9'(ln);
        line_req   = 1'b1;
        if (ln < 480) begin
            if (ln == 0) base_m = fl ? 22'h100000 : 22'h200000;
            if (fill_done) begin
                disp_m    = D_VALID;
                disp_addr = fill_addr;
            end else if (fill_active) begin
`ifdef FB_SCANOUT_UNDERRUN_EN
                disp_m = D_BLANK;
`else
                disp_m = D_UNKNOWN;
`endif
            end else disp_m = D_UNKNOWN;
`ifdef FB_SCANOUT_UNDERRUN_EN
            underrun_m = (underrun_m && ln != 0) || fill_active;
`endif
            fill_addr   = base_m + 22'(ln * 40);
            fill_active = 1;
            fill_done   = 0;
            fill_words  = 0;
            req_cyc     = cyc;
            exp_addr.delete();
            for (int i = 0; i < 40; i++) exp_addr.push_back(fill_addr + 22'(i));
        end
        @(posedge clk);
        #1;
        line_req = 1'b0;
        chk("underrun", 32'(underrun), 32'(underrun_m));
    endtask

    task automatic check_pixels(input int n);
        int  xs[5] = '{17, 0, 639, 640, 1023};
        px_t e;
        for (int i = 0; i < n; i++) begin
            int x;
            @(posedge clk);
            #1;
            x = (i < 5) ? xs[i] : int'($urandom_range(0, 1023));
            pix_x = 10'(x);
            e.c   = cyc;
            if (x >= 640 || disp_m == D_BLANK) begin
                e.v = 8'h00;
                pq.push_back(e);
            end else if (disp_m == D_VALID) begin
                e.v = pix_of(x, disp_addr);
                pq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (fill_active && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(fill_active), 32'd0);
        fill_active = 0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd", 32'(sdram_rd), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(line_ready), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_pix", 32'(pix_index), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // frame 0 drawn into FB0 region flag 0: scanout reads FB_BASE1
        ac_pct = 50;
        issue_req(0, 1'b0);
        wait_ready();
        issue_req(1, 1'b0);
        check_pixels(20);
        wait_ready();

        // back-to-back words, minimum line time
        ac_pct = 100;
        issue_req(0, 1'b1);
        wait_ready();
        chk("line_latency", 32'(ready_cyc - req_cyc), 32'd81);
        issue_req(5, 1'b1);
        check_pixels(20);
        wait_ready();

        // arbiter busy after word 3
        pause_at = 1;
        issue_req(7, 1'b1);
        n = 0;
        while (!sdram_wait && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("pause_seen", 32'(sdram_wait), 32'd1);
        repeat (3) @(negedge clk);
        chk("pause_rd", 32'(sdram_rd), 32'd0);
        chk("pause_busy", 32'(busy), 32'd0);
        wait_ready();

        // request arriving mid-fill
        ac_pct = 60;
        issue_req(9, 1'b1);
        n = 0;
        while (fill_words < 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("words_before_abort", 32'(fill_words >= 20), 32'd1);
        issue_req(11, 1'b1);
        check_pixels(12);
        wait_ready();
        issue_req(0, 1'b1);
        check_pixels(12);
        wait_ready();

        // out-of-range line: no access, no swap
        issue_req(480, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("oor_busy", 32'(busy), 32'd0);
            chk("oor_rd", 32'(sdram_rd), 32'd0);
        end
        check_pixels(10);

        // random lines with random arbiter activity
        rand_wait = 1;
        for (int k = 0; k < 6; k++) begin
            int ln;
            ln     = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 479));
            ac_pct = int'($urandom_range(30, 100));
            issue_req(ln, 1'($urandom_range(0, 1)));
            check_pixels(15);
            wait_ready();
        end
        rand_wait = 0;

        // asynchronous reset while a read is outstanding
        ac_pct = 0;
        issue_req(3, 1'b0);
        n = 0;
        while (!sdram_rd && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rd_before_reset", 32'(sdram_rd), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rd", 32'(sdram_rd), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", 32'(sdram_addr), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        exp_addr.delete();
        fill_active = 0;
        fill_done   = 0;
        underrun_m  = 0;
        base_m      = 22'h200000;
        disp_m      = D_UNKNOWN;
        ac_pct      = 50;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        issue_req(0, 1'b0);
        wait_ready();
        issue_req(2, 1'b0);
        check_pixels(15);
        wait_ready();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
